// File: rtl/mdu_iter_if.sv
// Request/result bundle between a pipeline front-end and the multiply/divide unit.
interface mdu_iter_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             flush;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             dz;

    modport master (
        output start, op, src_a, src_b, flush, hi_we, lo_we, wd,
        input  hi, lo, busy, dz
    );

    modport slave (
        input  start, op, src_a, src_b, flush, hi_we, lo_we, wd,
        output hi, lo, busy, dz
    );
endinterface

// File: rtl/mdu_iter.sv
// Fixed-latency multiply/divide unit with HI/LO accumulator registers.
//   state | meaning
//   IDLE  | waiting for start; direct HI/LO writes allowed when start is low
//   RUN   | operation in flight; down-counter reaches terminal count 1 on the completion edge
module mdu_iter #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic      clk,
    input  logic      reset,
    mdu_iter_if.slave bus
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);
    localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT);
    localparam logic [CW-1:0] DIV_CNT = CW'(DIV_LAT);
    localparam logic [CW-1:0] CNT_TC  = CW'(1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             dz_q;
    logic             accept, done, wr_ok;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (bus.start && !bus.flush) state_nx = RUN;
            RUN:  if (bus.flush || cnt == CNT_TC) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        accept   = (state == IDLE) && bus.start && !bus.flush;
        done     = (state == RUN) && (cnt == CNT_TC) && !bus.flush;
        wr_ok    = (state == IDLE) && !bus.start;
        bus.busy = (state == RUN) || accept;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            op_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
        end else if (accept) begin
            op_q <= bus.op;
            a_q  <= bus.src_a;
            b_q  <= bus.src_b;
            cnt  <= (bus.op[2:1] == 2'b01) ? DIV_CNT : MUL_CNT;
        end else if (state == RUN) begin
            cnt <= bus.flush ? '0 : cnt - 1'b1;
        end
    end

    logic                 is_div, sgn, a_neg, b_neg, b_zero;
    logic [WIDTH-1:0]     a_mag, b_mag, div_den, uq, ur, quo, rem;
    logic [2*WIDTH-1:0]   ax, bx, prod, acc, res;

    // Sign-extending to 2*WIDTH lets one unsigned multiplier serve both signednesses.
    // Dividing magnitudes also yields most-negative / -1 = most-negative with zero remainder.
    always_comb begin
        is_div  = (op_q[2:1] == 2'b01);
        sgn     = ~op_q[0];
        a_neg   = sgn & a_q[WIDTH-1];
        b_neg   = sgn & b_q[WIDTH-1];
        ax      = a_neg ? {{WIDTH{1'b1}}, a_q} : {{WIDTH{1'b0}}, a_q};
        bx      = b_neg ? {{WIDTH{1'b1}}, b_q} : {{WIDTH{1'b0}}, b_q};
        prod    = ax * bx;
        acc     = {hi_q, lo_q};
        a_mag   = a_neg ? -a_q : a_q;
        b_mag   = b_neg ? -b_q : b_q;
        b_zero  = (b_q == '0);
        div_den = b_zero ? WIDTH'(1) : b_mag;
        uq      = a_mag / div_den;
        ur      = a_mag % div_den;
        quo     = (a_neg ^ b_neg) ? -uq : uq;
        rem     = a_neg ? -ur : ur;
        case (op_q[2:1])
            2'b00:   res = prod;
            2'b01:   res = {rem, quo};
            2'b10:   res = acc + prod;
            default: res = acc - prod;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
            dz_q <= 1'b0;
        end else begin
            dz_q <= done && is_div && b_zero;
            if (done) begin
                if (!(is_div && b_zero)) {hi_q, lo_q} <= res;
            end else if (wr_ok) begin
                if (bus.hi_we) hi_q <= bus.wd;
                if (bus.lo_we) lo_q <= bus.wd;
            end
        end
    end

    assign bus.hi = hi_q;
    assign bus.lo = lo_q;
    assign bus.dz = dz_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: 32-bit (5/10 cycle) and 8-bit (1/3 cycle) instances.
module tb_mdu_iter;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MADD  = 3'b100;
    localparam logic [2:0] OP_MADDU = 3'b101;
    localparam logic [2:0] OP_MSUB  = 3'b110;
    localparam logic [2:0] OP_MSUBU = 3'b111;

    typedef struct {
        int          due;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        logic        busy;
        string       nm;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mdu_iter_if #(.WIDTH(32)) b32 ();
    mdu_iter_if #(.WIDTH(8))  b8 ();

    mdu_iter #(.WIDTH(32), .MUL_LAT(5), .DIV_LAT(10)) dut32 (.clk(clk), .reset(reset), .bus(b32));
    mdu_iter #(.WIDTH(8),  .MUL_LAT(1), .DIV_LAT(3))  dut8  (.clk(clk), .reset(reset), .bus(b8));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    exp_t q32[$];
    exp_t q8[$];
    logic [31:0] cur_hi[2];
    logic [31:0] cur_lo[2];

    function automatic void push(input bit s, input int due, input logic [31:0] h, input logic [31:0] l,
                                 input logic dz, input logic busy, input string nm);
        exp_t e;
        e.due = due; e.hi = h; e.lo = l; e.dz = dz; e.busy = busy; e.nm = nm;
        if (s) q8.push_back(e);
        else   q32.push_back(e);
    endfunction

    function automatic void check(input bit s, input exp_t e, input logic [31:0] ah, input logic [31:0] al,
                                  input logic adz, input logic abusy);
        n_tests++;
        if (e.due != cyc) begin
            n_fail++;
            $display("FAIL %s (%0d-bit): checked at cycle %0d, scheduled for %0d", e.nm, s ? 8 : 32, cyc, e.due);
        end else if (ah !== e.hi || al !== e.lo || adz !== e.dz || abusy !== e.busy) begin
            n_fail++;
            $display("FAIL %s (%0d-bit) cycle %0d: got hi=%h lo=%h dz=%b busy=%b, want hi=%h lo=%h dz=%b busy=%b",
                     e.nm, s ? 8 : 32, cyc, ah, al, adz, abusy, e.hi, e.lo, e.dz, e.busy);
        end
    endfunction

    exp_t m32, m8;
    always @(posedge clk) begin
        #1;
        while (q32.size() > 0 && q32[0].due <= cyc) begin
            m32 = q32.pop_front();
            check(1'b0, m32, b32.hi, b32.lo, b32.dz, b32.busy);
        end
    end

    always @(posedge clk) begin
        #1;
        while (q8.size() > 0 && q8[0].due <= cyc) begin
            m8 = q8.pop_front();
            check(1'b1, m8, {24'h0, b8.hi}, {24'h0, b8.lo}, b8.dz, b8.busy);
        end
    end

    task automatic drive(input bit s, input logic st, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic fl, input logic hwe, input logic lwe,
                         input logic [31:0] wd);
        if (s) begin
            b8.start = st; b8.op = op; b8.src_a = a[7:0]; b8.src_b = b[7:0];
            b8.flush = fl; b8.hi_we = hwe; b8.lo_we = lwe; b8.wd = wd[7:0];
        end else begin
            b32.start = st; b32.op = op; b32.src_a = a; b32.src_b = b;
            b32.flush = fl; b32.hi_we = hwe; b32.lo_we = lwe; b32.wd = wd;
        end
    endtask

    task automatic idle(input bit s);
        drive(s, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic idle_check(input bit s, input string nm);
        push(s, cyc + 1, cur_hi[s], cur_lo[s], 1'b0, 1'b0, nm);
        @(negedge clk);
    endtask

    // flush_at = k > 0 raises flush during the k-th RUN cycle; result then stays unchanged.
    task automatic do_op(input bit s, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                         input int flush_at, input string nm);
        int lat;
        int c;
        int fin;
        logic [31:0] rh, rl;
        logic rdz;
        lat = s ? ((op[2:1] == 2'b01) ? 3 : 1) : ((op[2:1] == 2'b01) ? 10 : 5);
        c = cyc;
        if (flush_at > 0) begin
            fin = c + 1 + flush_at; rh = cur_hi[s]; rl = cur_lo[s]; rdz = 1'b0;
        end else begin
            fin = c + 1 + lat; rh = ehi; rl = elo; rdz = edz;
        end
        drive(s, 1'b1, op, a, b, 1'b0, 1'b0, 1'b0, 32'h0);
        push(s, c + 1, cur_hi[s], cur_lo[s], 1'b0, 1'b1, {nm, "/run_first"});
        if (fin - 1 > c + 1) push(s, fin - 1, cur_hi[s], cur_lo[s], 1'b0, 1'b1, {nm, "/run_last"});
        push(s, fin, rh, rl, rdz, 1'b0, nm);
        push(s, fin + 1, rh, rl, 1'b0, 1'b0, {nm, "/after"});
        @(negedge clk);
        idle(s);
        for (int k = 1; k <= fin - c; k++) begin
            if (s) b8.flush = (k == flush_at);
            else   b32.flush = (k == flush_at);
            @(negedge clk);
        end
        idle(s);
        cur_hi[s] = rh;
        cur_lo[s] = rl;
    endtask

    task automatic dwrite(input bit s, input logic hwe, input logic lwe, input logic [31:0] wd, input string nm);
        logic [31:0] nh, nl;
        nh = hwe ? wd : cur_hi[s];
        nl = lwe ? wd : cur_lo[s];
        drive(s, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, hwe, lwe, wd);
        push(s, cyc + 1, nh, nl, 1'b0, 1'b0, nm);
        @(negedge clk);
        idle(s);
        cur_hi[s] = nh;
        cur_lo[s] = nl;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int c;
        idle(1'b0);
        idle(1'b1);
        cur_hi[0] = 32'h0; cur_lo[0] = 32'h0;
        cur_hi[1] = 32'h0; cur_lo[1] = 32'h0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        idle_check(1'b0, "reset_state");
        do_op(1'b0, OP_MULT,  32'hFFFFFFFD, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 0, "mult_neg3x5");
        do_op(1'b0, OP_MULTU, 32'hFFFFFFFD, 32'h5, 32'h00000004, 32'hFFFFFFF1, 1'b0, 0, "multu_big_x5");
        do_op(1'b0, OP_DIV,   32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 0, "div_neg7_by2");
        do_op(1'b0, OP_DIVU,  32'hFFFFFFF9, 32'h2, 32'h00000001, 32'h7FFFFFFC, 1'b0, 0, "divu_big_by2");
        do_op(1'b0, OP_DIVU,  32'h7, 32'h0, 32'h00000001, 32'h7FFFFFFC, 1'b1, 0, "divu_by_zero");
        do_op(1'b0, OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 0, "div_overflow");
        do_op(1'b0, OP_DIV,   32'h7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 1'b0, 0, "div_7_by_neg2");
        dwrite(1'b0, 1'b1, 1'b1, 32'hAAAA5555, "write_both");
        dwrite(1'b0, 1'b1, 1'b0, 32'h0, "write_hi");
        dwrite(1'b0, 1'b0, 1'b1, 32'h1, "write_lo");
        do_op(1'b0, OP_MADD,  32'h2, 32'h3, 32'h0, 32'h7, 1'b0, 0, "madd_2x3");
        do_op(1'b0, OP_MSUBU, 32'h1, 32'h8, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0, "msubu_1x8");
        do_op(1'b0, OP_MADDU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h0, 1'b0, 0, "maddu_wrap");
        do_op(1'b0, OP_MADD,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 1'b0, 0, "madd_neg1sq");
        do_op(1'b0, OP_MSUB,  32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h3, 1'b0, 0, "msub_neg_prod");

        // flush in third RUN cycle, new mult started in the very next cycle
        c = cyc;
        drive(1'b0, 1'b1, OP_DIVU, 32'h5, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        push(1'b0, c + 1,  cur_hi[0], cur_lo[0], 1'b0, 1'b1, "flush3/run_first");
        push(1'b0, c + 3,  cur_hi[0], cur_lo[0], 1'b0, 1'b1, "flush3/run_third");
        push(1'b0, c + 4,  cur_hi[0], cur_lo[0], 1'b0, 1'b0, "flush3/aborted");
        push(1'b0, c + 5,  cur_hi[0], cur_lo[0], 1'b0, 1'b1, "flush3/restart_no_dz");
        push(1'b0, c + 9,  cur_hi[0], cur_lo[0], 1'b0, 1'b1, "flush3/restart_last");
        push(1'b0, c + 10, 32'h0, 32'h2A, 1'b0, 1'b0, "flush3/mult_6x7");
        push(1'b0, c + 11, 32'h0, 32'h2A, 1'b0, 1'b0, "flush3/after");
        @(negedge clk); idle(1'b0);
        @(negedge clk);
        @(negedge clk); b32.flush = 1'b1;
        @(negedge clk); drive(1'b0, 1'b1, OP_MULT, 32'h6, 32'h7, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk); idle(1'b0);
        repeat (6) @(negedge clk);
        cur_hi[0] = 32'h0; cur_lo[0] = 32'h2A;

        do_op(1'b0, OP_DIVU, 32'h9, 32'h0, 32'h0, 32'h0, 1'b0, 10, "flush_on_completion");

        // start beats same-cycle write; start and writes during RUN are ignored
        c = cyc;
        drive(1'b0, 1'b1, OP_MULT, 32'h2, 32'h2, 1'b0, 1'b1, 1'b0, 32'hDEAD0000);
        push(1'b0, c + 1, cur_hi[0], cur_lo[0], 1'b0, 1'b1, "start_drops_write");
        push(1'b0, c + 3, cur_hi[0], cur_lo[0], 1'b0, 1'b1, "run_ignores_we_start");
        push(1'b0, c + 6, 32'h0, 32'h4, 1'b0, 1'b0, "mult_after_ignored");
        push(1'b0, c + 7, 32'h0, 32'h4, 1'b0, 1'b0, "mult_after_ignored/after");
        @(negedge clk); idle(1'b0);
        @(negedge clk); drive(1'b0, 1'b1, OP_DIV, 32'h9, 32'h3, 1'b0, 1'b1, 1'b1, 32'hBEEF);
        @(negedge clk); idle(1'b0);
        repeat (4) @(negedge clk);
        cur_hi[0] = 32'h0; cur_lo[0] = 32'h4;

        // flush with start in IDLE: start ignored, write dropped; then write with flush alone
        c = cyc;
        drive(1'b0, 1'b1, OP_MULT, 32'h3, 32'h3, 1'b1, 1'b1, 1'b0, 32'h12345678);
        push(1'b0, c + 1, cur_hi[0], cur_lo[0], 1'b0, 1'b0, "flush_blocks_start");
        push(1'b0, c + 2, cur_hi[0], 32'h0000ABCD, 1'b0, 1'b0, "flush_allows_write");
        @(negedge clk); drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0000ABCD);
        @(negedge clk); idle(1'b0);
        cur_lo[0] = 32'h0000ABCD;

        // reset mid-operation
        c = cyc;
        drive(1'b0, 1'b1, OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 32'h0);
        push(1'b0, c + 1, cur_hi[0], cur_lo[0], 1'b0, 1'b1, "reset_run/run_first");
        push(1'b0, c + 3, 32'h0, 32'h0, 1'b0, 1'b0, "reset_mid_run");
        push(1'b0, c + 4, 32'h0, 32'h0, 1'b0, 1'b0, "idle_after_reset");
        @(negedge clk); idle(1'b0);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        cur_hi[0] = 32'h0; cur_lo[0] = 32'h0;
        cur_hi[1] = 32'h0; cur_lo[1] = 32'h0;

        idle_check(1'b1, "reset_state8");
        do_op(1'b1, OP_MULT,  32'hFD, 32'h05, 32'hFF, 32'hF1, 1'b0, 0, "mult8_neg3x5");
        do_op(1'b1, OP_MULTU, 32'hFD, 32'h05, 32'h04, 32'hF1, 1'b0, 0, "multu8_253x5");
        do_op(1'b1, OP_DIV,   32'hF9, 32'h02, 32'hFF, 32'hFD, 1'b0, 0, "div8_neg7_by2");
        do_op(1'b1, OP_DIV,   32'h80, 32'hFF, 32'h00, 32'h80, 1'b0, 0, "div8_overflow");
        do_op(1'b1, OP_DIVU,  32'h80, 32'hFF, 32'h80, 32'h00, 1'b0, 0, "divu8_128_by255");
        do_op(1'b1, OP_DIVU,  32'h07, 32'h00, 32'h80, 32'h00, 1'b1, 0, "divu8_by_zero");
        do_op(1'b1, OP_DIV,   32'h80, 32'h03, 32'hFE, 32'hD6, 1'b0, 0, "div8_neg128_by3");
        do_op(1'b1, OP_MULT,  32'h80, 32'hFF, 32'h00, 32'h80, 1'b0, 0, "mult8_neg128xneg1");
        do_op(1'b1, OP_MADDU, 32'hFF, 32'hFF, 32'hFE, 32'h81, 1'b0, 0, "maddu8_255sq");
        do_op(1'b1, OP_MSUB,  32'h80, 32'h80, 32'hBE, 32'h81, 1'b0, 0, "msub8_neg128sq");
        do_op(1'b1, OP_MSUB,  32'h80, 32'h80, 32'h0, 32'h0, 1'b0, 1, "flush8_on_completion");

        for (int i = 0; i < 20; i++) begin
            if (q32.size() == 0 && q8.size() == 0) break;
            @(negedge clk);
        end
        if (q32.size() != 0 || q8.size() != 0) begin
            n_fail += q32.size() + q8.size();
            $display("FAIL drain: %0d expectations never checked, want 0", q32.size() + q8.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
